// File: rtl/kbd_scan_decoder_if.sv
// PS/2 receiver-FIFO handshake between ps2_keyboard (master) and the scan decoder (slave).
// Carries the head-of-FIFO byte, the non-empty and overflow flags, and the active-low pop strobe.
interface kbd_scan_decoder_if;
    logic [7:0] ps2_byte;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       nextdata_n;

    modport master (
        output ps2_byte,
        output ps2_ready,
        output ps2_overflow,
        input  nextdata_n
    );

    modport slave (
        input  ps2_byte,
        input  ps2_ready,
        input  ps2_overflow,
        output nextdata_n
    );
endinterface

// File: rtl/kbd_scan_decoder.sv
// PS/2 scan-code decoder: pops one FIFO byte per three cycles, strips F0/E0 prefixes,
// filters typematic repeats and reports held key, make code, ASCII and press count.
module kbd_scan_decoder #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    kbd_scan_decoder_if.slave  ps2,
    output logic               key_down,
    output logic [7:0]         scan_code,
    output logic [7:0]         ascii,
    output logic [COUNT_W-1:0] key_count,
    output logic               overflow_seen
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_byte;
    logic               r_nextdata_n;
    logic               r_brk_p;
    logic               r_ext_p;
    logic               r_scan_ext;
    logic               r_key_down;
    logic [7:0]         r_scan_code;
    logic [7:0]         r_ascii;
    logic [COUNT_W-1:0] r_key_count;
    logic               r_overflow_seen;
    logic               w_same_key;

    function automatic logic [7:0] ascii_lookup(input logic [7:0] code);
        case (code)
            8'h1C: ascii_lookup = 8'h61;  8'h32: ascii_lookup = 8'h62;
            8'h21: ascii_lookup = 8'h63;  8'h23: ascii_lookup = 8'h64;
            8'h24: ascii_lookup = 8'h65;  8'h2B: ascii_lookup = 8'h66;
            8'h34: ascii_lookup = 8'h67;  8'h33: ascii_lookup = 8'h68;
            8'h43: ascii_lookup = 8'h69;  8'h3B: ascii_lookup = 8'h6A;
            8'h42: ascii_lookup = 8'h6B;  8'h4B: ascii_lookup = 8'h6C;
            8'h3A: ascii_lookup = 8'h6D;  8'h31: ascii_lookup = 8'h6E;
            8'h44: ascii_lookup = 8'h6F;  8'h4D: ascii_lookup = 8'h70;
            8'h15: ascii_lookup = 8'h71;  8'h2D: ascii_lookup = 8'h72;
            8'h1B: ascii_lookup = 8'h73;  8'h2C: ascii_lookup = 8'h74;
            8'h3C: ascii_lookup = 8'h75;  8'h2A: ascii_lookup = 8'h76;
            8'h1D: ascii_lookup = 8'h77;  8'h22: ascii_lookup = 8'h78;
            8'h35: ascii_lookup = 8'h79;  8'h1A: ascii_lookup = 8'h7A;
            8'h45: ascii_lookup = 8'h30;  8'h16: ascii_lookup = 8'h31;
            8'h1E: ascii_lookup = 8'h32;  8'h26: ascii_lookup = 8'h33;
            8'h25: ascii_lookup = 8'h34;  8'h2E: ascii_lookup = 8'h35;
            8'h36: ascii_lookup = 8'h36;  8'h3D: ascii_lookup = 8'h37;
            8'h3E: ascii_lookup = 8'h38;  8'h46: ascii_lookup = 8'h39;
            8'h29: ascii_lookup = 8'h20;  8'h5A: ascii_lookup = 8'h0D;
            8'h66: ascii_lookup = 8'h08;
            default: ascii_lookup = 8'h00;
        endcase
    endfunction

    // Byte matches the stored key including its extended-ness (release match / repeat detect)
    assign w_same_key = (r_byte == r_scan_code) && (r_ext_p == r_scan_ext);

    // Handshake FSM and decode state; reset overrides everything including overflow capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_byte          <= 8'h00;
            r_nextdata_n    <= 1'b1;
            r_brk_p         <= 1'b0;
            r_ext_p         <= 1'b0;
            r_scan_ext      <= 1'b0;
            r_key_down      <= 1'b0;
            r_scan_code     <= 8'h00;
            r_ascii         <= 8'h00;
            r_key_count     <= '0;
            r_overflow_seen <= 1'b0;
        end else begin
            if (ps2.ps2_overflow) begin
                r_overflow_seen <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (ps2.ps2_ready) begin
                        r_byte       <= ps2.ps2_byte;
                        r_nextdata_n <= 1'b0;
                        r_state      <= ST_POP;
                    end else begin
                        r_nextdata_n <= 1'b1;
                    end
                end
                ST_POP: begin
                    r_nextdata_n <= 1'b1;
                    r_state      <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_nextdata_n <= 1'b1;
                    r_state      <= ST_IDLE;
                    if (r_byte == 8'hF0) begin
                        r_brk_p <= 1'b1;
                    end else if (r_byte == 8'hE0) begin
                        r_ext_p <= 1'b1;
                    end else if (r_brk_p) begin
                        if (w_same_key) begin
                            r_key_down <= 1'b0;
                        end
                        r_brk_p <= 1'b0;
                        r_ext_p <= 1'b0;
                    end else if (r_key_down && w_same_key) begin
                        r_ext_p <= 1'b0;
                    end else begin
                        // Extended keys never register as held and have no ASCII mapping
                        r_scan_code <= r_byte;
                        r_scan_ext  <= r_ext_p;
                        r_key_count <= r_key_count + {{(COUNT_W-1){1'b0}}, 1'b1};
                        r_ascii     <= r_ext_p ? 8'h00 : ascii_lookup(r_byte);
                        r_key_down  <= ~r_ext_p;
                        r_ext_p     <= 1'b0;
                    end
                end
                default: begin
                    r_nextdata_n <= 1'b1;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign ps2.nextdata_n = r_nextdata_n;
    assign key_down       = r_key_down;
    assign scan_code      = r_scan_code;
    assign ascii          = r_ascii;
    assign key_count      = r_key_count;
    assign overflow_seen  = r_overflow_seen;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench for kbd_scan_decoder: a small FIFO model stands in for ps2_keyboard,
// and every expected value below is hand-computed from the decode rules.
module tb_kbd_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_key_down;
    logic [7:0] w_scan_code;
    logic [7:0] w_ascii;
    logic [7:0] w_key_count;
    logic       w_overflow_seen;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] fifo_mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       ovf_drv = 1'b0;

    int cyc = 0;
    int low_cyc [$];
    logic prev_low = 1'b0;
    int back_to_back = 0;

    kbd_scan_decoder_if ps2 ();

    kbd_scan_decoder #(.COUNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2           (ps2.slave),
        .key_down      (w_key_down),
        .scan_code     (w_scan_code),
        .ascii         (w_ascii),
        .key_count     (w_key_count),
        .overflow_seen (w_overflow_seen)
    );

    always #5 clk = ~clk;

    assign ps2.ps2_ready    = (wr_ptr != rd_ptr);
    assign ps2.ps2_byte     = fifo_mem[rd_ptr % 1024];
    assign ps2.ps2_overflow = ovf_drv;

    // Receiver FIFO pops on the edge that ends a low nextdata_n cycle
    always @(posedge clk) begin
        if (ps2.nextdata_n == 1'b0 && wr_ptr != rd_ptr) rd_ptr <= rd_ptr + 1;
    end

    // Log the cycle of every pop strobe for pulse-count and spacing checks
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ps2.nextdata_n == 1'b0) begin
            low_cyc.push_back(cyc);
            if (prev_low) back_to_back <= back_to_back + 1;
        end
        prev_low <= (ps2.nextdata_n == 1'b0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr % 1024] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && rd_ptr != wr_ptr; i++) @(negedge clk);
        if (rd_ptr != wr_ptr) check("drain_timeout", 32'(rd_ptr), 32'(wr_ptr));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic kd, input logic [7:0] sc,
                               input logic [7:0] as, input logic [7:0] kc);
        check({tag, "_key_down"},  32'(w_key_down),  32'(kd));
        check({tag, "_scan_code"}, 32'(w_scan_code), 32'(sc));
        check({tag, "_ascii"},     32'(w_ascii),     32'(as));
        check({tag, "_key_count"}, 32'(w_key_count), 32'(kc));
    endtask

    int base;
    int spaced;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_nextdata_n", 32'(ps2.nextdata_n), 32'd1);
        check("rst_overflow", 32'(w_overflow_seen), 32'd0);
        check_state("rst", 1'b0, 8'h00, 8'h00, 8'h00);

        // Single press with cycle-exact latency
        push(8'h1C);
        @(negedge clk);
        check("a_pop_low", 32'(ps2.nextdata_n), 32'd0);
        check("a_scan_early", 32'(w_scan_code), 32'h00);
        @(negedge clk);
        check("a_pop_high", 32'(ps2.nextdata_n), 32'd1);
        check("a_count_early", 32'(w_key_count), 32'd0);
        @(negedge clk);
        check_state("a", 1'b1, 8'h1C, 8'h61, 8'd1);

        // Typematic repeats of '1' count once, then release
        push(8'h16); push(8'h16); push(8'h16);
        drain();
        check_state("rep", 1'b1, 8'h16, 8'h31, 8'd2);
        push(8'hF0); push(8'h16);
        drain();
        check_state("rel1", 1'b0, 8'h16, 8'h31, 8'd2);

        // Extended key: counted, never held, no ASCII
        push(8'hE0); push(8'h75);
        drain();
        check_state("ext_mk", 1'b0, 8'h75, 8'h00, 8'd3);
        push(8'hE0); push(8'hF0); push(8'h75);
        drain();
        check_state("ext_br", 1'b0, 8'h75, 8'h00, 8'd3);

        // Release of a non-matching code leaves key_down alone
        push(8'h1C);
        drain();
        check_state("a2", 1'b1, 8'h1C, 8'h61, 8'd4);
        push(8'hF0); push(8'h16);
        drain();
        check("other_rel_key_down", 32'(w_key_down), 32'd1);
        push(8'hF0); push(8'h1C);
        drain();
        check("a2_rel_key_down", 32'(w_key_down), 32'd0);

        // Back-to-back burst with ps2_ready held high
        base = low_cyc.size();
        push(8'h29); push(8'hF0); push(8'h29); push(8'h5A); push(8'hF0); push(8'h5A);
        drain();
        check("burst_pulses", 32'(low_cyc.size() - base), 32'd6);
        spaced = 0;
        for (int i = base + 1; i < low_cyc.size(); i++)
            if (low_cyc[i] - low_cyc[i-1] == 3) spaced++;
        check("burst_spacing", 32'(spaced), 32'd5);
        check("burst_single_cycle", 32'(back_to_back), 32'd0);
        check_state("burst", 1'b0, 8'h5A, 8'h0D, 8'd6);

        // Lookup corners: last letter and last digit
        push(8'h1A);
        drain();
        check_state("z", 1'b1, 8'h1A, 8'h7A, 8'd7);
        push(8'h46);
        drain();
        check_state("nine", 1'b1, 8'h46, 8'h39, 8'd8);

        // Counter wrap over 256 distinct presses
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            push((i % 2 == 0) ? 8'h29 : 8'h5A);
            push(8'hF0);
            push((i % 2 == 0) ? 8'h29 : 8'h5A);
            drain();
            if (i == 254) check_state("wrap_255", 1'b0, 8'h29, 8'h20, 8'd255);
        end
        check_state("wrap_0", 1'b0, 8'h5A, 8'h0D, 8'd0);

        // Sticky overflow survives traffic, clears only on reset
        ovf_drv = 1'b1;
        @(negedge clk);
        ovf_drv = 1'b0;
        check("ovf_set", 32'(w_overflow_seen), 32'd1);
        push(8'h1C);
        drain();
        check("ovf_sticky", 32'(w_overflow_seen), 32'd1);
        check("ovf_count", 32'(w_key_count), 32'd1);

        // Reset during POP discards the latched byte, and wins over overflow
        push(8'h32);
        @(negedge clk);
        check("rpop_low", 32'(ps2.nextdata_n), 32'd0);
        rst = 1'b1;
        ovf_drv = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ovf_drv = 1'b0;
        check("rpop_nextdata_n", 32'(ps2.nextdata_n), 32'd1);
        check("rpop_overflow", 32'(w_overflow_seen), 32'd0);
        check_state("rpop", 1'b0, 8'h00, 8'h00, 8'd0);
        repeat (4) @(negedge clk);
        check_state("rpop_late", 1'b0, 8'h00, 8'h00, 8'd0);
        check("rpop_fifo_empty", 32'(ps2.ps2_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
